scfifo_prog: RTL and testbench

Single-clock synchronous FIFO. It is the parametrised successor to the team's dual-clock FIFO for same-domain buffering.
- Adds arbitrary (non power-of-two) depth, selectable first-word-fall-through (FWFT) or registered-read mode, and almost-full/almost-empty thresholds.
- Exposes an exact fill count, sticky overflow/underflow error flags, and a synchronous flush.
- Sits between producer and consumer logic in one clock domain.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/scfifo_prog_if.sv | 34 +++
 rtl/fifo_ram.sv | 27 ++
 rtl/scfifo_prog.sv | 148 ++++++++++++++
 tb/tb_scfifo_prog.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Width and pointer-wrap helpers shared by the single- and dual-clock FIFO family.
// Depths need not be powers of two, so pointer wrap is an explicit compare.
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/scfifo_prog_if.sv
// Producer/consumer bundle for scfifo_prog; the FIFO sits on the slave modport.
interface scfifo_prog_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    import fifo_pkg::*;

    localparam int CW = cnt_w(DEPTH);

    logic             flush;
    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr, din, rd, clr_err,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, wr, din, rd, clr_err,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clock,
    input  logic                      i_we,
    input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
    output logic [WIDTH-1:0]          o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset so it can map onto RAM; control logic guards stale reads.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/scfifo_prog.sv
// Single-clock FIFO with arbitrary depth, FWFT or registered read, programmable
// almost-full/almost-empty levels, exact fill count, sticky error flags and flush.
module scfifo_prog
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 8,
    parameter int FWFT       = 1,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2
) (
    input  logic         clock,
    input  logic         resetn,
    scfifo_prog_if.slave bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < 2) begin : g_chk_depth
        $error("scfifo_prog: DEPTH must be >= 2");
    end
    if (WIDTH < 1) begin : g_chk_width
        $error("scfifo_prog: WIDTH must be >= 1");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_chk_afull
        $error("scfifo_prog: AFULL_LVL must be in 1..DEPTH");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_chk_aempty
        $error("scfifo_prog: AEMPTY_LVL must be in 0..DEPTH-1");
    end

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_afull;
    logic             r_aempty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wa;
    logic             w_ra;
    logic [PW-1:0]    w_wptr_inc;
    logic [PW-1:0]    w_rptr_inc;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_rdata;

    // Accept decisions use only the registered flags, so a full FIFO never writes through.
    assign w_wa = bus.wr && !r_full  && !bus.flush;
    assign w_ra = bus.rd && !r_empty && !bus.flush;

    assign w_wptr_inc = PW'(ptr_inc(32'(r_wptr), DEPTH));
    assign w_rptr_inc = PW'(ptr_inc(32'(r_rptr), DEPTH));

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_count_nxt = r_count;
        if (w_wa && !w_ra) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_ra && !w_wa) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn || bus.flush) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wa) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_ra) begin
                r_rptr <= w_rptr_inc;
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == CW'(DEPTH));
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= CW'(AFULL_LVL));
            r_aempty <= (w_count_nxt <= CW'(AEMPTY_LVL));
        end
    end

    // Error flags survive flush; a new error in the same cycle as clr_err wins.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr && r_full && !bus.flush) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end
            if (bus.rd && r_empty && !bus.flush) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_wa),
        .i_waddr (r_wptr),
        .i_wdata (bus.din),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Forced to zero while empty so reset and flush never expose unreset storage.
        assign bus.dout = r_empty ? '0 : w_rdata;
    end else begin : g_reg_read
        logic [WIDTH-1:0] r_dout;

        always_ff @(posedge clock) begin
            if (!resetn) begin
                r_dout <= '0;
            end else if (w_ra) begin
                r_dout <= w_rdata;
            end
        end

        assign bus.dout = r_dout;
    end

    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_scfifo_prog.sv
// Drives an FWFT and a registered-read scfifo_prog (DEPTH=6) with identical stimulus
// and checks both against a queue model every cycle, plus directed literal checks.
module tb_scfifo_prog;

    localparam int DEPTH = 6;
    localparam int WIDTH = 8;
    localparam int AFL   = 5;
    localparam int AEL   = 1;

    logic             clock = 1'b0;
    logic             resetn;
    logic             flush;
    logic             wr;
    logic             rd;
    logic             clr_err;
    logic [WIDTH-1:0] din;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    logic [WIDTH-1:0] q[$];
    logic             m_ovf;
    logic             m_udf;
    logic [WIDTH-1:0] m_dout_reg;

    always #5 clock = ~clock;

    scfifo_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_a ();
    scfifo_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_b ();

    assign if_a.flush = flush;   assign if_b.flush = flush;
    assign if_a.wr = wr;         assign if_b.wr = wr;
    assign if_a.rd = rd;         assign if_b.rd = rd;
    assign if_a.din = din;       assign if_b.din = din;
    assign if_a.clr_err = clr_err;  assign if_b.clr_err = clr_err;

    scfifo_prog #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL))
        u_dut_a (.clock(clock), .resetn(resetn), .bus(if_a));

    scfifo_prog #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL))
        u_dut_b (.clock(clock), .resetn(resetn), .bus(if_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue holds the contents; flags derive from its size.
    always @(posedge clock) begin
        if (!resetn) begin
            q.delete();
            m_ovf      = 1'b0;
            m_udf      = 1'b0;
            m_dout_reg = '0;
        end else begin
            bit was_full;
            bit was_empty;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (wr && was_full && !flush) m_ovf = 1'b1;
            else if (clr_err)             m_ovf = 1'b0;
            if (rd && was_empty && !flush) m_udf = 1'b1;
            else if (clr_err)              m_udf = 1'b0;
            if (flush) begin
                q.delete();
            end else begin
                if (rd && !was_empty) begin
                    m_dout_reg = q.pop_front();
                end
                if (wr && !was_full) begin
                    q.push_back(din);
                end
            end
        end
    end

    task automatic cmp_common(input string tag, input int n,
                              input logic [2:0] cnt, input logic f, input logic e,
                              input logic af, input logic ae, input logic ov, input logic un);
        check({tag, ".count"}, 32'(cnt), 32'(n));
        check({tag, ".full"}, 32'(f), 32'(n == DEPTH));
        check({tag, ".empty"}, 32'(e), 32'(n == 0));
        check({tag, ".almost_full"}, 32'(af), 32'(n >= AFL));
        check({tag, ".almost_empty"}, 32'(ae), 32'(n <= AEL));
        check({tag, ".overflow"}, 32'(ov), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(un), 32'(m_udf));
    endtask

    // Single compare process: every falling edge, both DUTs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            cmp_common("a", q.size(), if_a.count, if_a.full, if_a.empty,
                       if_a.almost_full, if_a.almost_empty, if_a.overflow, if_a.underflow);
            cmp_common("b", q.size(), if_b.count, if_b.full, if_b.empty,
                       if_b.almost_full, if_b.almost_empty, if_b.overflow, if_b.underflow);
            if (q.size() != 0) begin
                check("a.dout_fwft", 32'(if_a.dout), 32'(q[0]));
            end
            check("b.dout_reg", 32'(if_b.dout), 32'(m_dout_reg));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clock);
        @(negedge clock);
        wr  = 1'b0;
        rd  = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        int wb;

        resetn = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = '0;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        check("rst.count", 32'(if_a.count), 32'd0);
        check("rst.empty", 32'(if_a.empty), 32'd1);
        check("rst.aempty", 32'(if_b.almost_empty), 32'd1);
        check("rst.full", 32'(if_b.full), 32'd0);
        check("rst.dout_a", 32'(if_a.dout), 32'd0);
        check("rst.dout_b", 32'(if_b.dout), 32'd0);
        resetn = 1'b1;

        // Fill 0xA0..0xA5 and watch the thresholds move.
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'hA0 + 8'(i);
            cyc(1'b1, 1'b0, v);
            check("t1.count", 32'(if_a.count), 32'(i + 1));
            check("t1.aempty", 32'(if_a.almost_empty), 32'(i + 1 <= 1));
            check("t1.afull", 32'(if_a.almost_full), 32'(i + 1 >= 5));
            check("t1.full", 32'(if_b.full), 32'(i + 1 == 6));
        end

        cyc(1'b1, 1'b0, 8'hFF);
        check("t2.overflow", 32'(if_a.overflow), 32'd1);
        check("t2.count", 32'(if_b.count), 32'd6);
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'hA0 + 8'(i);
            check("t2.dout_a", 32'(if_a.dout), 32'(v));
            cyc(1'b0, 1'b1, 8'h00);
            check("t2.dout_b", 32'(if_b.dout), 32'(v));
        end
        check("t2.empty", 32'(if_a.empty), 32'd1);
        clr_err = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        clr_err = 1'b0;
        check("t2.ovf_clr", 32'(if_b.overflow), 32'd0);

        // Pointer wrap: three rounds of write-4/read-4 cross the 5->0 boundary.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 8'(8'h10 * (r + 1) + k));
            for (int k = 0; k < 4; k++) begin
                v = 8'(8'h10 * (r + 1) + k);
                check("t3.dout_a", 32'(if_a.dout), 32'(v));
                cyc(1'b0, 1'b1, 8'h00);
                check("t3.dout_b", 32'(if_b.dout), 32'(v));
            end
        end
        check("t3.count", 32'(if_a.count), 32'd0);

        check("t4.udf_pre", 32'(if_a.underflow), 32'd0);
        cyc(1'b1, 1'b1, 8'h3C);
        check("t4.underflow", 32'(if_a.underflow), 32'd1);
        check("t4.count1", 32'(if_b.count), 32'd1);
        check("t4.dout_a", 32'(if_a.dout), 32'h3C);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 8'(8'h40 + k));
        check("t4.full", 32'(if_a.full), 32'd1);
        cyc(1'b1, 1'b1, 8'h99);
        check("t4.count5", 32'(if_a.count), 32'd5);
        check("t4.overflow", 32'(if_b.overflow), 32'd1);
        check("t4.dout_b", 32'(if_b.dout), 32'h3C);

        flush = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        flush = 1'b0;
        cyc(1'b1, 1'b0, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b0, 1'b1, 8'h00);
        check("t5.dout_b1", 32'(if_b.dout), 32'h11);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("t5.hold", 32'(if_b.dout), 32'h11);
        cyc(1'b0, 1'b1, 8'h00);
        check("t5.dout_b2", 32'(if_b.dout), 32'h22);

        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'(8'h50 + k));
        check("t6.count3", 32'(if_a.count), 32'd3);
        flush = 1'b1;
        cyc(1'b1, 1'b1, 8'h55);
        flush = 1'b0;
        check("t6f.count", 32'(if_a.count), 32'd0);
        check("t6f.empty", 32'(if_b.empty), 32'd1);
        check("t6f.ovf", 32'(if_a.overflow), 32'd1);
        check("t6f.udf", 32'(if_b.underflow), 32'd1);
        check("t6f.dout_b", 32'(if_b.dout), 32'h22);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'(8'h60 + k));
        resetn = 1'b0;
        cyc(1'b1, 1'b1, 8'h66);
        resetn = 1'b1;
        check("t6r.count", 32'(if_b.count), 32'd0);
        check("t6r.empty", 32'(if_a.empty), 32'd1);
        check("t6r.aempty", 32'(if_a.almost_empty), 32'd1);
        check("t6r.afull", 32'(if_b.almost_full), 32'd0);
        check("t6r.ovf", 32'(if_a.overflow), 32'd0);
        check("t6r.udf", 32'(if_b.underflow), 32'd0);
        check("t6r.dout_a", 32'(if_a.dout), 32'd0);
        check("t6r.dout_b", 32'(if_b.dout), 32'd0);

        // Random traffic with alternating fill/drain bias to reach both ends often.
        for (int i = 0; i < 3000; i++) begin
            wb      = ((i / 200) % 2 == 0) ? 70 : 30;
            wr      = ($urandom_range(0, 99) < wb);
            rd      = ($urandom_range(0, 99) < (100 - wb));
            din     = 8'($urandom);
            flush   = ($urandom_range(0, 99) < 2);
            clr_err = ($urandom_range(0, 99) < 3);
            resetn  = ($urandom_range(0, 399) != 0);
            @(posedge clock);
            @(negedge clock);
        end
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; resetn = 1'b1;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
